// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8N1 UART receiver delivering bytes through a valid/ready holding register.
// Optional feature macro UART_RECEIVER_PARITY_EN adds an even-parity bit after the data bits.
module uart_receiver #(
  parameter int CLKS_PER_SAMPLE = 4,
  parameter int OVERSAMPLE      = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       parity_error
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RECEIVER_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

`ifdef UART_RECEIVER_PARITY_EN
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t          state_r, state_nx;
  logic            rx_meta_r, rx_s;
  logic [CW-1:0]   clk_cnt_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            deliver_r, ferr_pend_r;
  logic            tick_s, half_done_s, bit_done_s;
  logic            tick_clr_s, shift_en_s, stop_ok_s, stop_bad_s;
`ifdef UART_RECEIVER_PARITY_EN
  logic            par_smp_s, par_bad_r;
`endif

  assign tick_s      = (state_r != ST_IDLE) && (clk_cnt_r == CLK_LAST);
  assign half_done_s = tick_s && (tick_cnt_r == HALF_LAST);
  assign bit_done_s  = tick_s && (tick_cnt_r == BIT_LAST);

  // Two-flop synchronizer on the asynchronous rx pin
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx;
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_nx   = state_r;
    tick_clr_s = 1'b0;
    shift_en_s = 1'b0;
    stop_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
    par_smp_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        tick_clr_s = 1'b1;
        if (!rx_s) state_nx = ST_START;
        else       state_nx = ST_IDLE;
      end
      ST_START: begin
        if (half_done_s) begin
          tick_clr_s = 1'b1;
          if (rx_s) state_nx = ST_IDLE;
          else      state_nx = ST_DATA;
        end else begin
          state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          tick_clr_s = 1'b1;
          shift_en_s = 1'b1;
`ifdef UART_RECEIVER_PARITY_EN
          if (bit_cnt_r == 3'd7) state_nx = ST_PARITY;
`else
          if (bit_cnt_r == 3'd7) state_nx = ST_STOP;
`endif
          else                   state_nx = ST_DATA;
        end else begin
          state_nx = ST_DATA;
        end
      end
`ifdef UART_RECEIVER_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          tick_clr_s = 1'b1;
          par_smp_s  = 1'b1;
          state_nx   = ST_STOP;
        end else begin
          state_nx = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          tick_clr_s = 1'b1;
          if (rx_s) begin
            stop_ok_s = 1'b1;
            state_nx  = ST_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_nx   = ST_BREAK;
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      // A held-low line must return high before another start bit is accepted
      ST_BREAK: begin
        if (rx_s) state_nx = ST_IDLE;
        else      state_nx = ST_BREAK;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Sample-tick, tick and bit counters plus the LSB-first shift register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_cnt_r  <= CW'(0);
      tick_cnt_r <= TW'(0);
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) || tick_s) clk_cnt_r <= CW'(0);
      else                                clk_cnt_r <= clk_cnt_r + CW'(1);
      if (tick_clr_s)  tick_cnt_r <= TW'(0);
      else if (tick_s) tick_cnt_r <= tick_cnt_r + TW'(1);
      else             tick_cnt_r <= tick_cnt_r;
      if (state_r == ST_IDLE) bit_cnt_r <= 3'd0;
      else if (shift_en_s)    bit_cnt_r <= bit_cnt_r + 3'd1;
      else                    bit_cnt_r <= bit_cnt_r;
      if (shift_en_s) shift_r <= {rx_s, shift_r[7:1]};
      else            shift_r <= shift_r;
    end
  end

  // Holding register, handshake and one-cycle status pulses, one cycle after the stop sample
  always_ff @(posedge clk_in) begin
    if (rst) begin
      deliver_r     <= 1'b0;
      ferr_pend_r   <= 1'b0;
      data_out      <= 8'd0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      parity_error  <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      par_bad_r     <= 1'b0;
`endif
    end else begin
      deliver_r     <= stop_ok_s;
      ferr_pend_r   <= stop_bad_s;
      framing_error <= ferr_pend_r;
      if (deliver_r) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_r;
          data_valid <= 1'b1;
          overrun    <= 1'b0;
        end else begin
          overrun    <= 1'b1;
        end
      end else begin
        overrun <= 1'b0;
        if (data_valid && data_ready) data_valid <= 1'b0;
        else                          data_valid <= data_valid;
      end
`ifdef UART_RECEIVER_PARITY_EN
      if (par_smp_s) par_bad_r <= rx_s ^ parity8(shift_r);
      else           par_bad_r <= par_bad_r;
      parity_error <= deliver_r & par_bad_r;
`else
      parity_error <= 1'b0;
`endif
    end
  end

endmodule
